// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared constants and types for pipe_hazard_ctrl    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int FWD_NONE = 0;
  localparam int FWD_EXE  = 1;
  localparam int FWD_MEM  = 2;
  localparam int FWD_WB   = 3;

  localparam int MD_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    PRI_HALT  = 2'd0,
    PRI_STALL = 2'd1,
    PRI_FLUSH = 2'd2,
    PRI_RUN   = 2'd3
  } pri_e;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl_if : decoder/pipeline <-> hazard controller bus   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int NUM_FWD = 3,
  parameter int ADDR_W  = 5,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
  logic                      debug_en;
  logic                      debug_step;
  logic [ADDR_W-1:0]         rs_addr;
  logic [ADDR_W-1:0]         rt_addr;
  logic                      rs_used;
  logic                      rt_used;
  logic                      is_store;
  logic                      is_md;
  logic                      branch_taken;
  logic [NUM_FWD*ADDR_W-1:0] stg_waddr;
  logic [NUM_FWD-1:0]        stg_wen;
  logic [NUM_FWD-1:0]        stg_from_mem;

  logic [SEL_W-1:0]          fwd_a_sel;
  logic [SEL_W-1:0]          fwd_b_sel;
  logic                      store_late_fwd;
  logic                      if_en;
  logic                      id_en;
  logic                      exe_en;
  logic                      mem_en;
  logic                      wb_en;
  logic                      id_flush;
  logic                      exe_flush;
  logic                      md_busy;
  logic [31:0]               stall_cycles;

  modport master (
    output debug_en, debug_step, rs_addr, rt_addr, rs_used, rt_used,
           is_store, is_md, branch_taken, stg_waddr, stg_wen, stg_from_mem,
    input  fwd_a_sel, fwd_b_sel, store_late_fwd, if_en, id_en, exe_en,
           mem_en, wb_en, id_flush, exe_flush, md_busy, stall_cycles
  );

  modport slave (
    input  debug_en, debug_step, rs_addr, rt_addr, rs_used, rt_used,
           is_store, is_md, branch_taken, stg_waddr, stg_wen, stg_from_mem,
    output fwd_a_sel, fwd_b_sel, store_late_fwd, if_en, id_en, exe_en,
           mem_en, wb_en, id_flush, exe_flush, md_busy, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fwd_select : forwarding source select for one ID operand           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int ADDR_W  = 5,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      used,
  input  logic                      is_store,
  input  logic [NUM_FWD*ADDR_W-1:0] stg_waddr,
  input  logic [NUM_FWD-1:0]        stg_wen,
  input  logic [NUM_FWD-1:0]        stg_from_mem,
  output logic [SEL_W-1:0]          sel,
  output logic                      load_hit,
  output logic                      late_fwd
);

  logic [SEL_W-1:0] win;
  logic             exe_load;

  // Scan oldest to youngest so the lowest matching index is written last and wins.
  always_comb begin
    win = SEL_W'(FWD_NONE);
    if (used && (addr != '0)) begin
      for (int k = NUM_FWD; k >= 1; k--) begin
        if (stg_wen[k-1] && (stg_waddr[k*ADDR_W-1 -: ADDR_W] == addr)) begin
          win = SEL_W'(k);
        end
      end
    end
  end

  // Load data is not ready in EXE; only store data may pick it up late in MEM.
  assign exe_load = (win == SEL_W'(FWD_EXE)) && stg_from_mem[FWD_EXE-1];
  assign late_fwd = exe_load && is_store;
  assign load_hit = exe_load && !is_store;
  assign sel      = exe_load ? SEL_W'(FWD_NONE) : win;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : forwarding, stall, flush and debug-step control |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_FWD      = 3,
  parameter int ADDR_W       = 5,
  parameter int MD_LAT       = MD_LAT_DEFAULT,
  parameter int BRANCH_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int CNT_W = $clog2(MD_LAT + 1);

  logic [SEL_W-1:0] a_sel, b_sel;
  logic             a_load, b_load, a_late, b_late;
  logic             load_use, md_stall, step_pulse, halt;
  logic             if_en, id_en, exe_en, mem_en, wb_en, id_flush, exe_flush;
  pri_e             pri;

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             step_prev_q, step_prev_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  fwd_select #(.NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_fwd_rs (
    .addr(bus.rs_addr), .used(bus.rs_used), .is_store(1'b0),
    .stg_waddr(bus.stg_waddr), .stg_wen(bus.stg_wen), .stg_from_mem(bus.stg_from_mem),
    .sel(a_sel), .load_hit(a_load), .late_fwd(a_late)
  );

  fwd_select #(.NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_fwd_rt (
    .addr(bus.rt_addr), .used(bus.rt_used), .is_store(bus.is_store),
    .stg_waddr(bus.stg_waddr), .stg_wen(bus.stg_wen), .stg_from_mem(bus.stg_from_mem),
    .sel(b_sel), .load_hit(b_load), .late_fwd(b_late)
  );

  assign load_use   = a_load | b_load;
  assign md_stall   = (md_cnt_q != '0);
  assign step_pulse = bus.debug_step & ~step_prev_q;
  assign halt       = bus.debug_en & ~step_pulse;

  always_comb begin
    pri = PRI_RUN;
    if (halt)                                    pri = PRI_HALT;
    else if (md_stall || load_use)               pri = PRI_STALL;
    else if (bus.branch_taken && BRANCH_FLUSH != 0) pri = PRI_FLUSH;
  end

  always_comb begin
    if_en     = 1'b1;
    id_en     = 1'b1;
    exe_en    = 1'b1;
    mem_en    = 1'b1;
    wb_en     = 1'b1;
    id_flush  = 1'b0;
    exe_flush = 1'b0;
    case (pri)
      PRI_HALT: begin
        if_en  = 1'b0;
        id_en  = 1'b0;
        exe_en = 1'b0;
        mem_en = 1'b0;
        wb_en  = 1'b0;
      end
      PRI_STALL: begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        exe_flush = 1'b1;
      end
      PRI_FLUSH: id_flush = 1'b1;
      default: ;
    endcase
  end

  // mem_en is low only under halt, so a halt freezes the occupancy count.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (bus.is_md && id_en && !halt) begin
      md_cnt_d = CNT_W'(MD_LAT);
    end else if ((md_cnt_q != '0) && mem_en) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_comb begin
    step_prev_d    = bus.debug_step;
    stall_cycles_d = stall_cycles_q;
    if (!if_en && !halt && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q       <= '0;
      step_prev_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      md_cnt_q       <= md_cnt_d;
      step_prev_q    <= step_prev_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.fwd_a_sel      = a_sel;
  assign bus.fwd_b_sel      = b_sel;
  assign bus.store_late_fwd = a_late | b_late;
  assign bus.if_en          = if_en;
  assign bus.id_en          = id_en;
  assign bus.exe_en         = exe_en;
  assign bus.mem_en         = mem_en;
  assign bus.wb_en          = wb_en;
  assign bus.id_flush       = id_flush;
  assign bus.exe_flush      = exe_flush;
  assign bus.md_busy        = md_stall;
  assign bus.stall_cycles   = stall_cycles_q;

endmodule
`default_nettype wire
